// File: rtl/ws2812_rx_if.sv
// WS2812 receiver bus: serial line in, decoded pixel and frame status out.
// The receiver uses the master modport; a consumer/driver uses slave.
interface ws2812_rx_if #(
    parameter int LED_COUNT = 8
);
    localparam int IW = $clog2(LED_COUNT + 1);
    localparam int FW = IW + 1;

    logic          din;
    logic [23:0]   pixel;
    logic          pixel_valid;
    logic [IW-1:0] pixel_index;
    logic          frame_done;
    logic [FW-1:0] frame_count;
    logic          frame_error;
    logic          bit_error;
    logic          busy;

    modport master (
        input  din,
        output pixel,
        output pixel_valid,
        output pixel_index,
        output frame_done,
        output frame_count,
        output frame_error,
        output bit_error,
        output busy
    );

    modport slave (
        output din,
        input  pixel,
        input  pixel_valid,
        input  pixel_index,
        input  frame_done,
        input  frame_count,
        input  frame_error,
        input  bit_error,
        input  busy
    );
endinterface

// File: rtl/ws2812_rx.sv
// WS2812 bitstream receiver/checker. Measures every high pulse on the
// synchronized line, decodes it into a bit, packs 24 bits into a pixel word
// and delimits frames on the latch gap. Pulse-width violations, partial
// pixels and wrong pixel counts are reported with the end-of-frame strobe.
module ws2812_rx #(
    parameter int LED_COUNT    = 8,
    parameter int MIN_HIGH     = 8,
    parameter int BIT_THRESH   = 30,
    parameter int MAX_HIGH     = 50,
    parameter int RESET_CYCLES = 2000,
    parameter int CW           = 16
) (
    input  logic        clk,
    input  logic        reset,
    ws2812_rx_if.master bus
);
    localparam int IW = $clog2(LED_COUNT + 1);
    localparam int FW = IW + 1;

    // Pulse widths are compared on CW+1 bits so that cnt+1 cannot wrap.
    localparam logic [CW:0]    W_ONE    = (CW+1)'(1);
    localparam logic [CW:0]    MIN_W    = (CW+1)'(MIN_HIGH);
    localparam logic [CW:0]    THR_W    = (CW+1)'(BIT_THRESH);
    localparam logic [CW:0]    MAX_W    = (CW+1)'(MAX_HIGH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  MAX_CNT  = CW'(MAX_HIGH);
    localparam logic [CW-1:0]  GAP_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [IW-1:0]  IDX_ONE  = IW'(1);
    localparam logic [IW-1:0]  IDX_MAX  = IW'(LED_COUNT);
    localparam logic [FW-1:0]  FC_ONE   = FW'(1);
    localparam logic [FW-1:0]  FC_EXP   = FW'(LED_COUNT);
    localparam logic [4:0]     LAST_BIT = 5'd23;

    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        HIGH,
        LOW,
        RESYNC
    } state_t;

    state_t        state;

    logic          s1;
    logic          s2;
    logic          s3;
    logic          rise;
    logic          fall;

    logic [CW-1:0] cnt;
    logic [CW:0]   w;
    logic          bit_val;
    logic          gap_done;
    logic          end_frame;

    logic [23:0]   sr;
    logic [4:0]    bitcnt;
    logic [FW-1:0] pix_cnt;
    logic          err;
    logic          word_vld_p1;

    // Two-flop synchronizer for the asynchronous line plus one delay flop
    // for edge detection. Both edges see the same delay, so widths are exact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // Shared pulse/gap counter: restarts on every edge, saturates at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (rise | fall) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Pulse classification and gap/frame-end detection.
    always_comb begin
        w         = {1'b0, cnt} + W_ONE;
        bit_val   = (w >= THR_W);
        // Low for RESET_CYCLES consecutive cycles since the last falling edge.
        gap_done  = ~s2 & ~fall & (cnt == GAP_LAST);
        end_frame = 1'b0;
        if (state == LOW) begin
            end_frame = ~rise & gap_done;
        end else if (state == RESYNC) begin
            end_frame = gap_done;
        end
    end

    // Frame state machine with bit/pixel accumulation and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= SYNC;
            sr              <= '0;
            bitcnt          <= '0;
            pix_cnt         <= '0;
            err             <= 1'b0;
            word_vld_p1     <= 1'b0;
            bus.pixel       <= '0;
            bus.pixel_valid <= 1'b0;
            bus.pixel_index <= '0;
            bus.frame_done  <= 1'b0;
            bus.frame_count <= '0;
            bus.frame_error <= 1'b0;
            bus.bit_error   <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            bus.pixel_valid <= 1'b0;
            bus.frame_done  <= 1'b0;
            bus.bit_error   <= 1'b0;
            word_vld_p1     <= 1'b0;

            // ---- stage p1: publish a completed word one cycle after its last bit
            if (bus.pixel_valid) begin
                bus.pixel_index <= bus.pixel_index + IDX_ONE;
            end
            if (word_vld_p1 && (bus.pixel_index < IDX_MAX)) begin
                bus.pixel       <= sr;
                bus.pixel_valid <= 1'b1;
            end

            // ---- stage p0: edge-driven decode
            case (state)
                SYNC: begin
                    // Ignore everything until a full latch gap has been seen.
                    if (gap_done) begin
                        state <= IDLE;
                    end
                end

                IDLE: begin
                    if (rise) begin
                        state           <= HIGH;
                        sr              <= '0;
                        bitcnt          <= '0;
                        pix_cnt         <= '0;
                        err             <= 1'b0;
                        bus.pixel_index <= '0;
                        bus.busy        <= 1'b1;
                    end
                end

                HIGH: begin
                    if (fall) begin
                        if (w < MIN_W) begin
                            // Glitch: drop the bit, keep the partial pixel.
                            bus.bit_error <= 1'b1;
                            err           <= 1'b1;
                            state         <= LOW;
                        end else if (w > MAX_W) begin
                            bus.bit_error <= 1'b1;
                            err           <= 1'b1;
                            bitcnt        <= '0;
                            state         <= RESYNC;
                        end else begin
                            sr <= {sr[22:0], bit_val};
                            if (bitcnt == LAST_BIT) begin
                                bitcnt      <= '0;
                                word_vld_p1 <= 1'b1;
                                if (pix_cnt != '1) begin
                                    pix_cnt <= pix_cnt + FC_ONE;
                                end
                            end else begin
                                bitcnt <= bitcnt + 5'd1;
                            end
                            state <= LOW;
                        end
                    end else if (cnt == MAX_CNT) begin
                        // Stuck high: abandon the pixel and wait for a clean gap.
                        bus.bit_error <= 1'b1;
                        err           <= 1'b1;
                        bitcnt        <= '0;
                        state         <= RESYNC;
                    end
                end

                LOW: begin
                    if (rise) begin
                        state <= HIGH;
                    end
                end

                RESYNC: begin
                    // Rises only restart the gap count; nothing is decoded.
                end

                default: begin
                    state <= SYNC;
                end
            endcase

            if (end_frame) begin
                bus.frame_done  <= 1'b1;
                bus.frame_count <= pix_cnt;
                bus.frame_error <= err | (bitcnt != 5'd0) | (pix_cnt != FC_EXP);
                bus.busy        <= 1'b0;
                state           <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_ws2812_rx.sv
// Randomized bench for ws2812_rx: hand-drives WS2812 pulses and compares
// the decoded strobes against a pulse-level reference model.
module tb_ws2812_rx;
    localparam int LED_COUNT    = 8;
    localparam int MIN_HIGH     = 8;
    localparam int BIT_THRESH   = 30;
    localparam int MAX_HIGH     = 50;
    localparam int RESET_CYCLES = 2000;
    localparam int GAP          = RESET_CYCLES + 10;
    localparam logic [23:0] PAT [3] = '{24'hFF0000, 24'h00FF00, 24'h0000FF};

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    ws2812_rx_if #(.LED_COUNT(LED_COUNT)) bus();

    ws2812_rx #(
        .LED_COUNT(LED_COUNT), .MIN_HIGH(MIN_HIGH), .BIT_THRESH(BIT_THRESH),
        .MAX_HIGH(MAX_HIGH), .RESET_CYCLES(RESET_CYCLES), .CW(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed events
    logic [23:0] got_pix[$];
    int got_idx[$], got_pcyc[$], got_fc[$], got_fe[$], got_fcyc[$];
    int got_be = 0;

    // Expected events
    logic [23:0] exp_pix[$];
    int exp_idx[$], exp_pcyc[$], exp_fc[$], exp_fe[$], exp_fcyc[$];
    int exp_be = 0;

    // Reference model state
    bit          synced = 1'b0;
    bit          active = 1'b0;
    bit          resync = 1'b0;
    bit          merr = 1'b0;
    int          mbits = 0;
    int          mcount = 0;
    logic [23:0] mword = '0;
    int          last_fall = 0;

    always @(negedge clk) begin
        if (bus.pixel_valid === 1'b1) begin
            got_pix.push_back(bus.pixel);
            got_idx.push_back(int'(bus.pixel_index));
            got_pcyc.push_back(cyc);
        end
        if (bus.frame_done === 1'b1) begin
            got_fc.push_back(int'(bus.frame_count));
            got_fe.push_back(int'(bus.frame_error));
            got_fcyc.push_back(cyc);
        end
        if (bus.bit_error === 1'b1) got_be++;
    end

    task automatic clear_queues();
        got_pix.delete(); got_idx.delete(); got_pcyc.delete();
        got_fc.delete(); got_fe.delete(); got_fcyc.delete();
        exp_pix.delete(); exp_idx.delete(); exp_pcyc.delete();
        exp_fc.delete(); exp_fe.delete(); exp_fcyc.delete();
        got_be = 0;
        exp_be = 0;
    endtask

    // Model: one high pulse of h cycles whose first low sample is edge 'fall'.
    task automatic model_pulse(input int h, input int fall);
        last_fall = fall;
        if (!synced || resync) return;
        active = 1'b1;
        if (h < MIN_HIGH) begin
            exp_be++;
            merr = 1'b1;
        end else if (h > MAX_HIGH) begin
            exp_be++;
            merr = 1'b1;
            resync = 1'b1;
            mbits = 0;
        end else begin
            mword = {mword[22:0], (h >= BIT_THRESH) ? 1'b1 : 1'b0};
            mbits++;
            if (mbits == 24) begin
                mbits = 0;
                if (mcount < 31) mcount++;
                if (mcount <= LED_COUNT) begin
                    exp_pix.push_back(mword);
                    exp_idx.push_back(mcount - 1);
                    exp_pcyc.push_back(fall + 3);
                end
            end
        end
    endtask

    task automatic model_gap(input int n);
        if (n >= RESET_CYCLES) begin
            if (synced && active) begin
                exp_fc.push_back(mcount);
                exp_fe.push_back((merr || mbits != 0 || mcount != LED_COUNT) ? 1 : 0);
                exp_fcyc.push_back(last_fall + RESET_CYCLES + 2);
            end
            synced = 1'b1;
            active = 1'b0;
            resync = 1'b0;
            merr = 1'b0;
            mbits = 0;
            mcount = 0;
        end
    endtask

    task automatic model_reset();
        synced = 1'b0;
        active = 1'b0;
        resync = 1'b0;
        merr = 1'b0;
        mbits = 0;
        mcount = 0;
    endtask

    task automatic send_pulse(input int h, input int l);
        @(negedge clk);
        bus.din = 1'b1;
        repeat (h) @(negedge clk);
        bus.din = 1'b0;
        model_pulse(h, cyc + 1);
        repeat (l - 1) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        int h;
        h = b ? int'($urandom_range(40, 30)) : int'($urandom_range(29, 10));
        send_pulse(h, int'($urandom_range(16, 8)));
    endtask

    task automatic send_word(input logic [23:0] word);
        for (int i = 23; i >= 0; i--) send_bit(word[i]);
    endtask

    task automatic gap(input int n);
        bus.din = 1'b0;
        repeat (n) @(negedge clk);
        model_gap(n);
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        checks++;
        if (bus.pixel !== 24'h0) begin
            errors++; $display("FAIL reset_pixel: got %h expected 000000", bus.pixel);
        end
        checks++;
        if (bus.pixel_index !== '0 || bus.frame_count !== '0) begin
            errors++; $display("FAIL reset_counts: got index %0d count %0d expected 0 0", bus.pixel_index, bus.frame_count);
        end
        checks++;
        if ({bus.pixel_valid, bus.frame_done, bus.frame_error, bus.bit_error, bus.busy} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 00000",
                {bus.pixel_valid, bus.frame_done, bus.frame_error, bus.bit_error, bus.busy});
        end
        reset = 1'b0;
        gap(GAP);
        checks++;
        if (got_pix.size() + got_fc.size() + got_be !== 0) begin
            errors++; $display("FAIL reset_quiet: got %0d events expected 0", got_pix.size() + got_fc.size() + got_be);
        end
    endtask

    task automatic test_nominal();
        clear_queues();
        for (int i = 0; i < LED_COUNT; i++) begin
            send_word(PAT[i % 3]);
            if (i == 0) begin
                checks++;
                if (bus.busy !== 1'b1) begin
                    errors++; $display("FAIL nominal_busy: got %b expected 1", bus.busy);
                end
            end
        end
        gap(GAP);
        checks++;
        if (bus.busy !== 1'b0 || bus.pixel !== PAT[(LED_COUNT - 1) % 3]) begin
            errors++; $display("FAIL nominal_hold: got busy %b pixel %h expected 0 %h", bus.busy, bus.pixel, PAT[(LED_COUNT - 1) % 3]);
        end
        checks++;
        if (got_pix.size() !== exp_pix.size()) begin
            errors++; $display("FAIL nominal_strobes: got %0d expected %0d", got_pix.size(), exp_pix.size());
        end
        foreach (exp_pix[i]) if (i < got_pix.size()) begin
            checks++;
            if (got_pix[i] !== exp_pix[i] || got_idx[i] !== exp_idx[i] || got_pcyc[i] !== exp_pcyc[i]) begin
                errors++; $display("FAIL nominal_pixel%0d: got %h idx %0d cyc %0d expected %h idx %0d cyc %0d",
                    i, got_pix[i], got_idx[i], got_pcyc[i], exp_pix[i], exp_idx[i], exp_pcyc[i]);
            end
        end
        checks++;
        if (got_fc.size() !== 1 || got_fc.size() !== exp_fc.size()) begin
            errors++; $display("FAIL nominal_frames: got %0d expected 1", got_fc.size());
        end else begin
            checks++;
            if (got_fc[0] !== LED_COUNT || got_fe[0] !== 0 || got_fcyc[0] !== exp_fcyc[0]) begin
                errors++; $display("FAIL nominal_frame: got count %0d err %0d cyc %0d expected %0d 0 cyc %0d",
                    got_fc[0], got_fe[0], got_fcyc[0], LED_COUNT, exp_fcyc[0]);
            end
        end
        checks++;
        if (got_be !== 0) begin
            errors++; $display("FAIL nominal_biterr: got %0d expected 0", got_be);
        end
    endtask

    // Generic scenario: n full random words plus extra random bits, then a gap.
    task automatic run_frame(input int n, input int extra);
        for (int i = 0; i < n; i++) send_word(24'($urandom));
        for (int i = 0; i < extra; i++) send_bit(1'($urandom));
        gap(GAP);
    endtask

    task automatic test_back_to_back();
        clear_queues();
        run_frame(LED_COUNT, 0);
        checks++;
        if (got_pix.size() !== exp_pix.size()) begin
            errors++; $display("FAIL b2b_strobes: got %0d expected %0d", got_pix.size(), exp_pix.size());
        end
        foreach (exp_pix[i]) if (i < got_pix.size()) begin
            checks++;
            if (got_pix[i] !== exp_pix[i] || got_idx[i] !== exp_idx[i] || got_pcyc[i] !== exp_pcyc[i]) begin
                errors++; $display("FAIL b2b_pixel%0d: got %h idx %0d cyc %0d expected %h idx %0d cyc %0d",
                    i, got_pix[i], got_idx[i], got_pcyc[i], exp_pix[i], exp_idx[i], exp_pcyc[i]);
            end
        end
        checks++;
        if (got_fc.size() !== exp_fc.size() || got_fc.size() == 0) begin
            errors++; $display("FAIL b2b_frames: got %0d expected %0d", got_fc.size(), exp_fc.size());
        end else begin
            checks++;
            if (got_fc[0] !== exp_fc[0] || got_fe[0] !== exp_fe[0] || got_be !== exp_be) begin
                errors++; $display("FAIL b2b_frame: got count %0d err %0d biterr %0d expected %0d %0d %0d",
                    got_fc[0], got_fe[0], got_be, exp_fc[0], exp_fe[0], exp_be);
            end
        end
    endtask

    task automatic test_thresholds();
        clear_queues();
        // 29 -> 0, 30 -> 1, 8 -> 0, 50 -> 1, then a legal remainder and a 7-cycle glitch
        send_pulse(29, 10);
        send_pulse(30, 10);
        send_pulse(MIN_HIGH, 10);
        send_pulse(MAX_HIGH, 10);
        for (int i = 0; i < 20; i++) send_bit(1'($urandom));
        send_pulse(7, 12);
        gap(GAP);
        // One good word, then a 51-cycle pulse
        send_word(24'($urandom));
        send_pulse(51, 10);
        send_bit(1'b1);
        gap(GAP);
        // Five bits, then a line stuck high for 60 cycles
        for (int i = 0; i < 5; i++) send_bit(1'($urandom));
        send_pulse(60, 10);
        gap(GAP);
        checks++;
        if (got_pix.size() !== exp_pix.size()) begin
            errors++; $display("FAIL thr_strobes: got %0d expected %0d", got_pix.size(), exp_pix.size());
        end
        foreach (exp_pix[i]) if (i < got_pix.size()) begin
            checks++;
            if (got_pix[i] !== exp_pix[i] || got_idx[i] !== exp_idx[i] || got_pcyc[i] !== exp_pcyc[i]) begin
                errors++; $display("FAIL thr_pixel%0d: got %h idx %0d cyc %0d expected %h idx %0d cyc %0d",
                    i, got_pix[i], got_idx[i], got_pcyc[i], exp_pix[i], exp_idx[i], exp_pcyc[i]);
            end
        end
        if (got_pix.size() > 0) begin
            checks++;
            if (got_pix[0][23:20] !== 4'b0101) begin
                errors++; $display("FAIL thr_edges: got %b expected 0101", got_pix[0][23:20]);
            end
        end
        checks++;
        if (got_fc.size() !== exp_fc.size()) begin
            errors++; $display("FAIL thr_frames: got %0d expected %0d", got_fc.size(), exp_fc.size());
        end
        foreach (exp_fc[i]) if (i < got_fc.size()) begin
            checks++;
            if (got_fc[i] !== exp_fc[i] || got_fe[i] !== 1 || got_fcyc[i] !== exp_fcyc[i]) begin
                errors++; $display("FAIL thr_frame%0d: got count %0d err %0d cyc %0d expected %0d 1 cyc %0d",
                    i, got_fc[i], got_fe[i], got_fcyc[i], exp_fc[i], exp_fcyc[i]);
            end
        end
        checks++;
        if (got_be !== 3 || exp_be !== 3) begin
            errors++; $display("FAIL thr_biterr: got %0d expected 3", got_be);
        end
    endtask

    task automatic test_truncated_overlong(input int n, input int extra, input string tag);
        clear_queues();
        run_frame(n, extra);
        checks++;
        if (got_pix.size() !== exp_pix.size() || got_pix.size() !== ((n < LED_COUNT) ? n : LED_COUNT)) begin
            errors++; $display("FAIL %s_strobes: got %0d expected %0d", tag, got_pix.size(), exp_pix.size());
        end
        foreach (exp_pix[i]) if (i < got_pix.size()) begin
            checks++;
            if (got_pix[i] !== exp_pix[i] || got_idx[i] !== exp_idx[i] || got_pcyc[i] !== exp_pcyc[i]) begin
                errors++; $display("FAIL %s_pixel%0d: got %h idx %0d cyc %0d expected %h idx %0d cyc %0d",
                    tag, i, got_pix[i], got_idx[i], got_pcyc[i], exp_pix[i], exp_idx[i], exp_pcyc[i]);
            end
        end
        checks++;
        if (got_fc.size() !== 1) begin
            errors++; $display("FAIL %s_frames: got %0d expected 1", tag, got_fc.size());
        end else begin
            checks++;
            if (got_fc[0] !== n || got_fe[0] !== 1 || got_fcyc[0] !== exp_fcyc[0]) begin
                errors++; $display("FAIL %s_frame: got count %0d err %0d cyc %0d expected %0d 1 cyc %0d",
                    tag, got_fc[0], got_fe[0], got_fcyc[0], n, exp_fcyc[0]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_queues();
        for (int i = 0; i < 3; i++) send_word(24'($urandom));
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (bus.pixel !== 24'h0 || bus.pixel_index !== '0 || bus.busy !== 1'b0 || bus.frame_count !== '0) begin
            errors++; $display("FAIL midreset_async: got pixel %h idx %0d busy %b count %0d expected 0 0 0 0",
                bus.pixel, bus.pixel_index, bus.busy, bus.frame_count);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 3; i < LED_COUNT; i++) send_word(24'($urandom));
        checks++;
        if (got_pix.size() !== 3 || got_fc.size() !== 0) begin
            errors++; $display("FAIL midreset_ignored: got %0d strobes %0d frames expected 3 0", got_pix.size(), got_fc.size());
        end
        gap(GAP);
        run_frame(LED_COUNT, 0);
        checks++;
        if (got_pix.size() !== exp_pix.size()) begin
            errors++; $display("FAIL midreset_strobes: got %0d expected %0d", got_pix.size(), exp_pix.size());
        end
        foreach (exp_pix[i]) if (i < got_pix.size()) begin
            checks++;
            if (got_pix[i] !== exp_pix[i] || got_idx[i] !== exp_idx[i] || got_pcyc[i] !== exp_pcyc[i]) begin
                errors++; $display("FAIL midreset_pixel%0d: got %h idx %0d cyc %0d expected %h idx %0d cyc %0d",
                    i, got_pix[i], got_idx[i], got_pcyc[i], exp_pix[i], exp_idx[i], exp_pcyc[i]);
            end
        end
        checks++;
        if (got_fc.size() !== 1 || exp_fc.size() !== 1) begin
            errors++; $display("FAIL midreset_frames: got %0d expected 1", got_fc.size());
        end else begin
            checks++;
            if (got_fc[0] !== LED_COUNT || got_fe[0] !== 0 || got_fcyc[0] !== exp_fcyc[0]) begin
                errors++; $display("FAIL midreset_frame: got count %0d err %0d cyc %0d expected %0d 0 cyc %0d",
                    got_fc[0], got_fe[0], got_fcyc[0], LED_COUNT, exp_fcyc[0]);
            end
        end
    endtask

    task automatic test_startup();
        clear_queues();
        @(negedge clk);
        reset = 1'b1;
        bus.din = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        bus.din = 1'b0;
        repeat (12) @(negedge clk);
        for (int i = 0; i < 2; i++) send_word(24'($urandom));
        checks++;
        if (got_pix.size() + got_fc.size() + got_be !== 0) begin
            errors++; $display("FAIL startup_quiet: got %0d events expected 0", got_pix.size() + got_fc.size() + got_be);
        end
        gap(GAP);
        run_frame(4, 0);
        checks++;
        if (got_pix.size() !== exp_pix.size() || got_pix.size() !== 4) begin
            errors++; $display("FAIL startup_strobes: got %0d expected 4", got_pix.size());
        end
        foreach (exp_pix[i]) if (i < got_pix.size()) begin
            checks++;
            if (got_pix[i] !== exp_pix[i] || got_idx[i] !== exp_idx[i]) begin
                errors++; $display("FAIL startup_pixel%0d: got %h idx %0d expected %h idx %0d",
                    i, got_pix[i], got_idx[i], exp_pix[i], exp_idx[i]);
            end
        end
        checks++;
        if (got_fc.size() !== 1 || got_fc[0] !== 4 || got_fe[0] !== 1) begin
            errors++; $display("FAIL startup_frame: got %0d frames expected one with count 4 err 1", got_fc.size());
        end
    endtask

    initial begin
        bus.din = 1'b0;
        test_reset();
        test_nominal();
        test_back_to_back();
        test_thresholds();
        test_truncated_overlong(2, 10, "truncated");
        test_truncated_overlong(LED_COUNT + 1, 0, "overlong");
        test_reset_mid_frame();
        test_startup();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ws2812_rx.md
# ws2812_rx

Cycle-accurate WS2812 bitstream receiver and checker: decodes the single-wire NRZ stream produced by the `ws2812_driver` back into 24-bit pixel words and delimits frames on the latch (reset) gap. It sits on the driver's `dout` in simulation benches and on a loopback pin in hardware self-test. It flags timing violations, truncated pixels and wrong pixel counts.

## Interface

Parameters:

- `LED_COUNT`, 8: pixels expected per frame.
- `MIN_HIGH`, 8: shortest legal high pulse, in cycles. Shorter pulses are glitches.
- `BIT_THRESH`, 30: high width ≥ this decodes as 1; below decodes as 0.
- `MAX_HIGH`, 50: longest legal high pulse, in cycles.
- `RESET_CYCLES`, 2000: low time that ends a frame (40 µs at 50 MHz).
- `CW`, 16: width of the pulse/gap counter.

Ports:

- `clk`, in, 1: system clock, 50 MHz.
- `reset`, in, 1: asynchronous, active-high reset.
- `din`, in, 1: WS2812 serial line, asynchronous to `clk`.
- `pixel`, out, 24: last decoded word, MSB first as transmitted (G,R,B byte order untouched).
- `pixel_valid`, out, 1: one-cycle strobe when `pixel` is updated.
- `pixel_index`, out, clog2(LED_COUNT+1): index of the current `pixel` within the frame.
- `frame_done`, out, 1: one-cycle strobe at the end of a frame.
- `frame_count`, out, clog2(LED_COUNT+1)+1: pixels decoded in the finished frame (saturating). Valid with `frame_done`.
- `frame_error`, out, 1: valid with `frame_done`. Set on bit error, partial pixel, or `frame_count` ≠ LED_COUNT.
- `bit_error`, out, 1: one-cycle strobe on any pulse-width violation.
- `busy`, out, 1: high from the first rising edge of a frame until `frame_done`.

## Operation

- `din` passes through a 2-flop synchronizer (`s1`, `s2`), then a delay register `s3`.
  - rise = `s2 & ~s3`
  - fall = `~s2 & s3`
- A single counter `cnt` (CW bits) saturates at all-ones.
  - It clears on every edge.
  - Otherwise it increments every cycle.
- State machine:
  - **SYNC** (reset state): the line must be low for RESET_CYCLES consecutive cycles, then go to IDLE. A rise during SYNC clears `cnt` and the FSM stays in SYNC; no output is produced.
  - **IDLE**: on rise, go to HIGH and clear the bit/pixel accumulators, `pixel_index` and the error flag; `busy` goes to 1.
  - **HIGH**: on fall, classify `w = cnt+1` (high width in cycles):
    - MIN_HIGH ≤ w ≤ MAX_HIGH: shift bit `(w ≥ BIT_THRESH)` into the 24-bit shift register LSB and go to LOW.
    - w < MIN_HIGH: `bit_error` pulse, set the frame error flag, discard the bit, go to LOW.
    - If `cnt` reaches MAX_HIGH while still high: `bit_error` pulse, set the error flag, discard the partial pixel, go to RESYNC.
  - **LOW**: on rise, go to HIGH. If `cnt` reaches RESET_CYCLES−1, end the frame and go to IDLE.
  - **RESYNC**: wait for low ≥ RESET_CYCLES, then end the frame (error flag set) and go to IDLE.
- On the 24th accepted bit:
  - If fewer than LED_COUNT pixels have been emitted: `pixel` ← shift register, `pixel_valid` pulses, then `pixel_index` increments after the strobe.
  - Otherwise: the pixel is dropped but still counted (saturating), which forces `frame_error`.
  - The bit counter wraps to 0 in both cases.
- End of frame:
  - `frame_done` pulses with `frame_count`.
  - `frame_error` = flag | (bitcnt ≠ 0) | (count ≠ LED_COUNT).
  - `busy` falls in the same cycle as `frame_done`.
- A glitch in LOW is detected at its fall as w < MIN_HIGH; the LOW gap count restarts.

## Timing

- Reset values:
  - `pixel` = 0, `pixel_index` = 0, `frame_count` = 0.
  - All strobes = 0, `busy` = 0.
  - State = SYNC.
- Reset is asynchronous and fully restores the reset values mid-frame. After release the receiver re-enters SYNC, so a frame already in flight is ignored until the next latch gap.
- Latency:
  - `pixel_valid` is asserted 4 clk edges after the first edge at which `din` is sampled low ending the 24th bit.
  - `frame_done` is asserted 3 + RESET_CYCLES edges after the last falling `din` sample.
- Measured high width equals the driver's high width in cycles exactly, since the synchronizer delays both edges equally.
- Strobes are never asserted in consecutive cycles: a legal bit is at least MIN_HIGH+1 cycles apart.
- `pixel` holds its value between strobes.

## Test plan

- **Nominal frame**: drive `ws2812_driver` (LED_COUNT=8) with FF0000, 00FF00, 0000FF repeating.
  - Expect 8 `pixel_valid` strobes with matching words at index 0..7.
  - Expect `frame_done` with `frame_count`=8, `frame_error`=0, and no `bit_error`.
  - Repeat back-to-back; the second frame must decode identically.
- **Thresholds**: hand-driven pulses of 29 and 30 high cycles decode as 0 and 1. 7 cycles gives `bit_error`. 51 cycles gives `bit_error`, RESYNC, and then `frame_error`=1.
- **Truncated frame**: send 2 pixels plus 10 bits, then low for 2000 cycles.
  - Expect 2 strobes, then `frame_done` with `frame_count`=2 and `frame_error`=1.
- **Overlong frame**: send 9 pixels.
  - Expect 8 strobes, `frame_count`=9 and `frame_error`=1.
- **Reset mid-frame**: assert `reset` after pixel 3 of 8.
  - Outputs return to reset values immediately.
  - The remaining pixels produce no strobe.
  - The next full frame decodes cleanly.
- **Start-up**: `din` high at reset release.
  - No strobe until low ≥ 2000 cycles has been observed.
